seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed 7-segment scan driver downstream of the 74LS161-style BCD/hex counter chain.
//  Takes the packed counter nibbles (Q buses) and per-digit controls, and drives one digit at a time.
//  Provides frame-coherent snapshots, anti-ghost blanking, leading-zero suppression and blinking.
//  Sits between the clock counter stages and the board's common-anode display pins.
// PARAMETERS
//  N_DIGITS     8      digits scanned; 2..8
//  SCAN_DIV     50000  CP cycles per digit slot; >= GHOST_CYC+2
//  GHOST_CYC    500    cycles at start of each slot with all anodes off
//  BLINK_FRAMES 250    full frames per blink half-period; >= 1
//  LZ_BLANK     1      1 = suppress leading zeros (digit N_DIGITS-1 downward; digit 0 never blanked)
// PORTS
//  CP           in   1            clock, rising edge
//  CR           in   1            reset, asynchronous, active-low
//  digits       in   4*N_DIGITS   nibble i = digits[4i+3:4i], hex value of digit i (digit 0 = rightmost)
//  dp_in        in   N_DIGITS     decimal point request per digit, 1 = lit
//  blank_mask   in   N_DIGITS     1 = digit forced dark
//  blink_mask   in   N_DIGITS     1 = digit dark during blink-off phase
//  AN           out  N_DIGITS     anode enables, active-low; at most one bit low
//  SEG          out  8            {dp,g,f,e,d,c,b,a}, active-low
//  frame_start  out  1            one-cycle pulse when slot index wraps to 0
// BEHAVIOUR
//  Reset (CR=0, async): div_cnt=0, idx=0, frame_cnt=0, blink_ph=0 (visible), snapshot=0,
//   AN = all 1, SEG = 8'hFF, frame_start=0. Outputs stay dark until first slot completes its ghost window.
//  Slot timer: div_cnt counts 0..SCAN_DIV-1, then wraps to 0; at wrap, idx <= (idx==N_DIGITS-1) ? 0 : idx+1.
//  Frame: when idx wraps N_DIGITS-1 -> 0, on the same edge: snapshot <= {digits,dp_in,blank_mask,blink_mask};
//   frame_start pulses high for exactly that one cycle; frame_cnt increments.
//   When frame_cnt reaches BLINK_FRAMES-1, it wraps to 0 and blink_ph toggles.
//  Inputs are sampled only at frame boundaries; mid-frame changes are never displayed until the next frame.
//  Ghost window: while div_cnt < GHOST_CYC, AN = all 1 and SEG = 8'hFF.
//  Active window: AN[idx]=0, other bits 1; SEG = decode(snapshot nibble idx) with dp = ~dp_snap[idx],
//   unless dark. Dark (SEG=8'hFF, AN still driven) when any of: blank_snap[idx]; blink_snap[idx] && blink_ph;
//   LZ_BLANK && idx!=0 && all nibbles idx..N_DIGITS-1 are 0 && !dp_snap[idx].
//  Decode (active-low a..g): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E
//   (shown as {dp=1,g..a}); dp bit then overridden per dp rule.
//  AN/SEG are registered: they reflect the idx/div_cnt of the previous cycle (1-cycle latency), glitch-free.
//  Reset mid-frame: immediate dark outputs; on release, scanning restarts at idx 0 with zero snapshot.
//  Slot index never exceeds N_DIGITS-1; exactly one frame_start per N_DIGITS*SCAN_DIV cycles.
// STRUCTURE
//  Shared package seg7_pkg: SEG_OFF=8'hFF, AN_OFF, hex-to-segment table as a constant function.
//  One sub-module: seg7_hex_decode (4-bit in, 7-bit active-low out, combinational).
//  Top holds the slot timer, index counter, frame/blink counters, snapshot and output registers.
// TESTING
//  Use N_DIGITS=4, SCAN_DIV=10, GHOST_CYC=2, BLINK_FRAMES=2 for all directed cases.
//  Reset: hold CR=0 5 cycles -> AN=4'hF, SEG=8'hFF, frame_start=0; release -> AN[0] low first at cycle 3-4.
//  Scan order: digits=16'h1234, masks 0 -> AN cycles E,D,B,7 every 10 clocks; SEG C0?no: 99,B0,A4,F9 for idx0..3;
//   frame_start pulses once every 40 cycles; AN=F during the first 2 cycles of each slot.
//  Snapshot: change digits to 16'h5678 mid-frame -> old values shown until the next frame_start, then 5678 values.
//  LZ blanking: digits=16'h0070, LZ_BLANK=1 -> idx3,idx2 dark (SEG=FF), idx1=F8, idx0=C0; set dp_in[3]=1 -> idx3 SEG=7F.
//  Blink: blink_mask=4'b0001 -> digit 0 shown 2 frames, dark 2 frames, repeating; others always lit.
//  Async reset mid-slot (idx=2, div_cnt=5) -> outputs dark within the same cycle, restart at idx 0 after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment table for the 7-segment scan driver.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    typedef enum logic {
        SLOT_GHOST,
        SLOT_ACTIVE
    } slot_phase_e;

    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(hex);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver: frame-coherent snapshot, ghost blanking,
// leading-zero suppression and blinking, registered glitch-free AN/SEG outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 8,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned GHOST_CYC    = 500,
    parameter int unsigned BLINK_FRAMES = 250,
    parameter bit          LZ_BLANK     = 1'b1
) (
    input  logic                    CP,
    input  logic                    CR,
    input  logic [4*N_DIGITS-1:0]   digits,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blank_mask,
    input  logic [N_DIGITS-1:0]     blink_mask,
    output logic [N_DIGITS-1:0]     AN,
    output logic [7:0]              SEG,
    output logic                    frame_start
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned IW = $clog2(N_DIGITS);
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DW-1:0]           div_cnt;
    logic [IW-1:0]           idx;
    logic [FW-1:0]           frame_cnt;
    logic                    blink_ph;
    logic [4*N_DIGITS-1:0]   snap_digits;
    logic [N_DIGITS-1:0]     snap_dp;
    logic [N_DIGITS-1:0]     snap_blank;
    logic [N_DIGITS-1:0]     snap_blink;

    logic                    slot_end;
    logic                    frame_end;
    slot_phase_e             phase;
    logic [3:0]              nib;
    logic                    dp_sel;
    logic                    blank_sel;
    logic                    blink_sel;
    logic                    upper_nz;
    logic [6:0]              dec_seg;
    logic [N_DIGITS-1:0]     an_nxt;
    logic [7:0]              seg_nxt;

    always_comb begin
        slot_end  = (div_cnt == DW'(SCAN_DIV - 1));
        frame_end = slot_end && (idx == IW'(N_DIGITS - 1));
        phase     = (div_cnt < DW'(GHOST_CYC)) ? SLOT_GHOST : SLOT_ACTIVE;
    end

    // Select the snapshot fields of the current slot; upper_nz covers digits idx..top.
    always_comb begin
        nib       = 4'h0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        blink_sel = 1'b0;
        upper_nz  = 1'b0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib       = snap_digits[4*i +: 4];
                dp_sel    = snap_dp[i];
                blank_sel = snap_blank[i];
                blink_sel = snap_blink[i];
            end
            if ((IW'(i) >= idx) && (snap_digits[4*i +: 4] != 4'h0)) begin
                upper_nz = 1'b1;
            end
        end
    end

    seg7_hex_decode u_dec (
        .hex (nib),
        .seg (dec_seg)
    );

    // A suppressed leading zero with its dp requested shows the dp alone.
    always_comb begin
        an_nxt  = AN_OFF[N_DIGITS-1:0];
        seg_nxt = SEG_OFF;
        if (phase == SLOT_ACTIVE) begin
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                an_nxt[i] = (idx != IW'(i));
            end
            if (blank_sel || (blink_sel && blink_ph)) begin
                seg_nxt = SEG_OFF;
            end else if (LZ_BLANK && (idx != '0) && !upper_nz) begin
                seg_nxt = {~dp_sel, 7'h7F};
            end else begin
                seg_nxt = {~dp_sel, dec_seg};
            end
        end
    end

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            div_cnt     <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_ph    <= 1'b0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            snap_blink  <= '0;
            AN          <= AN_OFF[N_DIGITS-1:0];
            SEG         <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= slot_end ? '0 : div_cnt + DW'(1);
            frame_start <= frame_end;
            AN          <= an_nxt;
            SEG         <= seg_nxt;
            if (slot_end) begin
                idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);
            end
            if (frame_end) begin
                snap_digits <= digits;
                snap_dp     <= dp_in;
                snap_blank  <= blank_mask;
                snap_blink  <= blink_mask;
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed scoreboard bench for seg7_scan_driver (4 digits, 10-cycle slots, 2-cycle ghost).
module tb_seg7_scan_driver;

    localparam int unsigned ND   = 4;
    localparam int unsigned DIV  = 10;
    localparam int unsigned GH   = 2;
    localparam int unsigned BLF  = 2;
    localparam int unsigned FRM  = ND * DIV;

    logic           CP;
    logic           CR;
    logic [15:0]    digits;
    logic [3:0]     dp_in;
    logic [3:0]     blank_mask;
    logic [3:0]     blink_mask;
    logic [3:0]     AN;
    logic [7:0]     SEG;
    logic           frame_start;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t           q[$];
    exp_t           cur;
    int unsigned    n_chk;
    int unsigned    n_fail;
    int unsigned    c;

    logic [7:0] dec_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg7_scan_driver #(
        .N_DIGITS     (ND),
        .SCAN_DIV     (DIV),
        .GHOST_CYC    (GH),
        .BLINK_FRAMES (BLF),
        .LZ_BLANK     (1'b1)
    ) dut (
        .CP          (CP),
        .CR          (CR),
        .digits      (digits),
        .dp_in       (dp_in),
        .blank_mask  (blank_mask),
        .blink_mask  (blink_mask),
        .AN          (AN),
        .SEG         (SEG),
        .frame_start (frame_start)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, want, c);
        end
    endtask

    // Expected per-slot AN/SEG for frame k given the inputs captured at its boundary.
    task automatic push_frame(input int unsigned k, input logic [15:0] d, input logic [3:0] dp,
                              input logic [3:0] bl, input logic [3:0] bk);
        exp_t e;
        logic uz;
        logic ph;
        ph = ((k / BLF) % 2) == 1;
        for (int unsigned i = 0; i < ND; i++) begin
            uz = 1'b1;
            for (int unsigned j = i; j < ND; j++) begin
                if (d[4*j +: 4] != 4'h0) uz = 1'b0;
            end
            e.an = ~(4'b0001 << i);
            if (bl[i] || (bk[i] && ph))
                e.seg = 8'hFF;
            else if (i != 0 && uz)
                e.seg = dp[i] ? 8'h7F : 8'hFF;
            else
                e.seg = dec_tab[d[4*i +: 4]] & (dp[i] ? 8'h7F : 8'hFF);
            q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge CP);
        #1;
        c++;
        chk("frame_start", {7'h0, frame_start}, (c % FRM == 0) ? 8'h01 : 8'h00);
    endtask

    task automatic run_slot();
        int unsigned dv;
        for (int unsigned s = 0; s < DIV; s++) begin
            step();
            dv = (c - 1) % DIV;
            if (dv < GH) begin
                chk("ghost_an", {4'h0, AN}, 8'h0F);
                chk("ghost_seg", SEG, 8'hFF);
            end else begin
                if (dv == GH) begin
                    n_chk++;
                    assert (q.size() != 0) else begin
                        n_fail++;
                        $error("FAIL scoreboard_empty observed=0 expected=nonzero at cycle %0d", c);
                    end
                    if (q.size() != 0) cur = q.pop_front();
                end
                chk("slot_an", {4'h0, AN}, {4'h0, cur.an});
                chk("slot_seg", SEG, cur.seg);
            end
            if (c % FRM == 0) push_frame(c / FRM, digits, dp_in, blank_mask, blink_mask);
        end
    endtask

    task automatic run_frames(input int unsigned n);
        for (int unsigned f = 0; f < n * ND; f++) run_slot();
    endtask

    task automatic reset_hold(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge CP);
            #1;
            chk("rst_an", {4'h0, AN}, 8'h0F);
            chk("rst_seg", SEG, 8'hFF);
            chk("rst_fs", {7'h0, frame_start}, 8'h00);
        end
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        c          = 0;
        cur        = '0;
        CR         = 1'b0;
        digits     = 16'h0000;
        dp_in      = 4'h0;
        blank_mask = 4'h0;
        blink_mask = 4'h0;

        reset_hold(5);
        CR = 1'b1;
        c  = 0;
        push_frame(0, 16'h0000, 4'h0, 4'h0, 4'h0);

        // Frame 0 shows the zero snapshot; 1234 is captured at its end.
        digits = 16'h1234;
        run_frames(1);

        // Mid-frame change must not appear until the following frame.
        run_slot();
        run_slot();
        digits = 16'h5678;
        run_slot();
        run_slot();
        run_frames(1);

        // Leading-zero suppression, then dp on the top leading zero.
        digits = 16'h0070;
        run_frames(2);
        dp_in = 4'b1000;
        run_frames(1);

        // Forced blank, then blink on digit 0 across two blink periods.
        dp_in      = 4'h0;
        digits     = 16'h1234;
        blank_mask = 4'b0100;
        run_frames(1);
        blank_mask = 4'h0;
        blink_mask = 4'b0001;
        run_frames(5);

        // Asynchronous reset at idx 2, div_cnt 5.
        run_slot();
        run_slot();
        for (int unsigned i = 0; i < 5; i++) step();
        chk("pre_rst_an", {4'h0, AN}, 8'h0B);
        CR = 1'b0;
        #1;
        chk("async_an", {4'h0, AN}, 8'h0F);
        chk("async_seg", SEG, 8'hFF);
        chk("async_fs", {7'h0, frame_start}, 8'h00);
        reset_hold(3);
        q.delete();
        CR = 1'b1;
        c  = 0;
        push_frame(0, 16'h0000, 4'h0, 4'h0, 4'h0);
        run_frames(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
